seq_detect_sched: RTL and testbench

Round-robin scheduler that shares one serial "1101" Moore sequence detector among NUM_REQ requesters. Each requester presents a parallel word. The block grants one requester at a time, shifts the granted word MSB-first through the internal detector, and counts overlapping "1101" matches. It then reports the count, a found flag and the requester ID with a one-cycle done pulse. It sits between word-producing clients and the serial detection datapath.

---
 rtl/seq_detect_sched.sv | 141 ++++++++++++++
 tb/tb_seq_detect_sched.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/seq_detect_sched.sv
// Round-robin scheduler sharing one serial "1101" Moore detector among NUM_REQ requesters.
// A granted word is shifted MSB-first. Overlapping matches are counted and reported with a done pulse.
module seq_detect_sched #(
  parameter int NUM_REQ   = 2,
  parameter int WORD_BITS = 8,
  parameter int CNT_BITS  = 4,
  parameter int ID_BITS   = 1
) (
  input  logic                           clk,
  input  logic                           n_rst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*WORD_BITS-1:0]   req_data,
  output logic [NUM_REQ-1:0]             grant,
  output logic                           busy,
  output logic                           det_o,
  output logic                           done,
  output logic [ID_BITS-1:0]             done_id,
  output logic [CNT_BITS-1:0]            match_count,
  output logic                           found
);

  localparam int BC_BITS = $clog2(WORD_BITS + 1);
  localparam int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [BC_BITS-1:0]  LAST_CNT = BC_BITS'(WORD_BITS);
  localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;
  localparam logic [NUM_REQ-1:0]  ONE_REQ  = NUM_REQ'(1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  typedef enum logic [2:0] {S0, S1, S11, S110, S1101} det_t;

  state_t                state_reg, state_next;
  det_t                  det_reg, det_next;
  logic [WORD_BITS-1:0]  shift_reg;
  logic [BC_BITS-1:0]    bit_cnt_reg;
  logic [CNT_BITS-1:0]   match_cnt_reg;
  logic [ID_BITS-1:0]    last_grant_reg;

  logic                  sel_valid;
  logic [ID_BITS-1:0]    sel_id;
  logic [WORD_BITS-1:0]  sel_word;
  logic                  shifting;

  logic [WORD_BITS-1:0]  words [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_words
    assign words[gi] = req_data[gi*WORD_BITS +: WORD_BITS];
  end

  // Scan from the requester after the last grant, wrapping, and take the first one asking.
  always_comb begin
    int         idx;
    logic [IW-1:0] idx_w;
    idx       = 0;
    idx_w     = '0;
    sel_valid = 1'b0;
    sel_id    = last_grant_reg;
    sel_word  = words[0];
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx   = (int'(last_grant_reg) + i) % NUM_REQ;
      idx_w = IW'(idx);
      if (!sel_valid && req[idx_w]) begin
        sel_valid = 1'b1;
        sel_id    = ID_BITS'(idx);
        sel_word  = words[idx_w];
      end
    end
  end

  always_comb begin
    det_next = S0;
    case (det_reg)
      S0:      det_next = shift_reg[WORD_BITS-1] ? S1    : S0;
      S1:      det_next = shift_reg[WORD_BITS-1] ? S11   : S0;
      S11:     det_next = shift_reg[WORD_BITS-1] ? S11   : S110;
      S110:    det_next = shift_reg[WORD_BITS-1] ? S1101 : S0;
      S1101:   det_next = shift_reg[WORD_BITS-1] ? S11   : S0;
      default: det_next = S0;
    endcase
  end

  assign shifting = (state_reg == SHIFT) && (bit_cnt_reg != LAST_CNT);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (sel_valid) state_next = SHIFT;
      SHIFT:   if (bit_cnt_reg == LAST_CNT) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      grant          <= '0;
      busy           <= 1'b0;
      det_o          <= 1'b0;
      done           <= 1'b0;
      done_id        <= '0;
      match_count    <= '0;
      found          <= 1'b0;
      det_reg        <= S0;
      shift_reg      <= '0;
      bit_cnt_reg    <= '0;
      match_cnt_reg  <= '0;
      last_grant_reg <= ID_BITS'(NUM_REQ - 1);
    end else begin
      grant <= '0;
      done  <= 1'b0;
      busy  <= (state_next != IDLE);
      if (state_reg == IDLE && sel_valid) begin
        shift_reg      <= sel_word;
        det_reg        <= S0;
        det_o          <= 1'b0;
        bit_cnt_reg    <= '0;
        match_cnt_reg  <= '0;
        last_grant_reg <= sel_id;
        grant          <= ONE_REQ << sel_id;
      end else if (shifting) begin
        shift_reg   <= shift_reg << 1;
        det_reg     <= det_next;
        det_o       <= (det_next == S1101);
        bit_cnt_reg <= bit_cnt_reg + 1'b1;
        if (det_next == S1101 && match_cnt_reg != CNT_MAX)
          match_cnt_reg <= match_cnt_reg + 1'b1;
      end else if (state_reg == SHIFT) begin
        // Final SHIFT edge: the last bit was consumed on the previous edge, so publish results.
        done        <= 1'b1;
        done_id     <= last_grant_reg;
        match_count <= match_cnt_reg;
        found       <= (match_cnt_reg != '0);
      end
    end
  end

endmodule

// File: tb/tb_seq_detect_sched.sv
// Directed + randomized bench for seq_detect_sched.
// Expected grant order and match counts are produced by a substring-counting round-robin model.
module tb_seq_detect_sched;
  localparam int NUM_REQ   = 2;
  localparam int WORD_BITS = 8;
  localparam int CNT_BITS  = 4;
  localparam int ID_BITS   = 1;

  logic                         clk;
  logic                         n_rst;
  logic [NUM_REQ-1:0]           req;
  logic [NUM_REQ*WORD_BITS-1:0] req_data;
  logic [NUM_REQ-1:0]           grant;
  logic                         busy;
  logic                         det_o;
  logic                         done;
  logic [ID_BITS-1:0]           done_id;
  logic [CNT_BITS-1:0]          match_count;
  logic                         found;

  int checks = 0;
  int errors = 0;
  int model_last = NUM_REQ - 1;

  seq_detect_sched #(
    .NUM_REQ(NUM_REQ), .WORD_BITS(WORD_BITS), .CNT_BITS(CNT_BITS), .ID_BITS(ID_BITS)
  ) dut (
    .clk(clk), .n_rst(n_rst), .req(req), .req_data(req_data), .grant(grant),
    .busy(busy), .det_o(det_o), .done(done), .done_id(done_id),
    .match_count(match_count), .found(found)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Overlapping occurrences of "1101" read MSB-first.
  function automatic int count_1101(input logic [WORD_BITS-1:0] w);
    int n = 0;
    for (int i = 0; i <= WORD_BITS - 4; i++)
      if (w[WORD_BITS-1-i -: 4] == 4'b1101) n++;
    return n;
  endfunction

  function automatic int rr_pick(input logic [NUM_REQ-1:0] r, input int last);
    for (int i = 1; i <= NUM_REQ; i++)
      if (r[(last + i) % NUM_REQ]) return (last + i) % NUM_REQ;
    return -1;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_grant"}, grant, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_det_o"}, det_o, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_done_id"}, done_id, 0);
    check({tag, "_match_count"}, match_count, 0);
    check({tag, "_found"}, found, 0);
  endtask

  task automatic do_reset();
    req = '0;
    @(posedge clk);
    #3 n_rst = 1'b0;
    #1 check_all_zero("rst_async");
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    check_all_zero("rst_release");
    model_last = NUM_REQ - 1;
  endtask

  // Called at a negedge; requesters in rq join any still-pending requests.
  task automatic do_job(input logic [NUM_REQ-1:0] rq, input logic [WORD_BITS-1:0] d0,
                        input logic [WORD_BITS-1:0] d1);
    int sel, n, exp_cnt, det_hits;
    logic [WORD_BITS-1:0] w;
    if (!req[0]) req_data[0*WORD_BITS +: WORD_BITS] = d0;
    if (!req[1]) req_data[1*WORD_BITS +: WORD_BITS] = d1;
    req = req | rq;
    sel = rr_pick(req, model_last);
    w = req_data[sel*WORD_BITS +: WORD_BITS];
    exp_cnt = count_1101(w);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (grant == '0 && n < 40);
    check("grant_timeout", (grant == '0) ? 32'd1 : 32'd0, 0);
    if (grant == '0) return;
    check("grant", grant, NUM_REQ'(1) << sel);
    check("busy_at_grant", busy, 1);
    check("det_o_at_grant", det_o, 0);
    check("done_at_grant", done, 0);
    model_last = sel;
    req[sel] = 1'b0;
    det_hits = 0;
    for (int j = 1; j <= WORD_BITS; j++) begin
      @(negedge clk);
      if (j == 1) check("grant_one_cycle", grant, 0);
      check("busy_shift", busy, 1);
      check("done_early", done, 0);
      det_hits += int'(det_o);
    end
    @(negedge clk);
    check("done_pulse", done, 1);
    check("done_id", done_id, sel);
    check("match_count", match_count, (exp_cnt > 15) ? 15 : exp_cnt);
    check("found", found, (exp_cnt != 0) ? 1 : 0);
    check("det_o_pulses", det_hits, exp_cnt);
    $display("job req=%b sel=%0d word=%b matches=%0d done_id=%0d count=%0d",
             rq, sel, w, exp_cnt, done_id, match_count);
  endtask

  initial begin
    int n_done;
    logic [NUM_REQ-1:0] rq;
    n_rst = 1'b1;
    req = '0;
    req_data = '0;

    // Reset behaviour
    do_reset();

    // Directed single-requester jobs
    do_job(2'b01, 8'b1101_0000, 8'h00);
    do_job(2'b10, 8'h00, 8'b1101_1010);
    do_job(2'b01, 8'b1100_1100, 8'h00);
    @(negedge clk);
    check("idle_done_low", done, 0);
    check("idle_busy_low", busy, 0);

    // Both requesters contend; grants must alternate
    do_reset();
    for (int k = 0; k < 4; k++)
      do_job(2'b11, 8'($urandom), 8'($urandom));

    // Reset mid-word aborts it without a done pulse
    do_reset();
    req_data[WORD_BITS-1:0] = 8'b1101_1101;
    req = 2'b01;
    @(negedge clk);
    check("abort_grant", grant, 2'b01);
    req = '0;
    repeat (3) @(posedge clk);
    #2 n_rst = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_det_o", det_o, 0);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    model_last = NUM_REQ - 1;
    n_done = 0;
    repeat (12) begin
      @(negedge clk);
      n_done += int'(done);
    end
    check("abort_no_done", n_done, 0);
    do_job(2'b01, 8'b0001_1010, 8'h00);

    // Randomized traffic
    for (int k = 0; k < 16; k++) begin
      rq = 2'($urandom_range(1, 3));
      do_job(rq, 8'($urandom), 8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
